// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types, constants and config helpers for the UART receive path
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2,
    DONE,
    BREAK_WAIT
  } rx_state_e;

  localparam int MIN_DATA_WIDTH = 5;
  localparam int PRESCALE_8     = 8;
  localparam int PRESCALE_16    = 16;
  localparam int PRESCALE_32    = 32;

  // Out-of-range width requests are pulled into MIN_DATA_WIDTH..max_w.
  function automatic logic [3:0] clamp_width(input logic [3:0] cfg, input int max_w);
    logic [3:0] w;
    w = cfg;
    if (int'(cfg) < MIN_DATA_WIDTH) w = 4'(MIN_DATA_WIDTH);
    else if (int'(cfg) > max_w) w = 4'(max_w);
    return w;
  endfunction

endpackage

// File: rtl/uart_rx_frame_controller_if.sv
// rtl/uart_rx_frame_controller_if.sv - line, config and result signals of the UART receive controller
interface uart_rx_frame_controller_if #(
  parameter int MAX_DATA_WIDTH = 9,
  parameter int PRESCALE_WIDTH = 6
);
  logic                      enable;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic [3:0]                data_width_cfg;
  logic                      parity_enable;
  logic                      parity_type;
  logic                      two_stop_bits;
  logic                      serial_data;
  logic [MAX_DATA_WIDTH-1:0] rx_data;
  logic                      data_valid;
  logic                      parity_error;
  logic                      framing_error;
  logic                      break_detected;
  logic                      busy;

  modport master (
    output enable, prescale, data_width_cfg, parity_enable, parity_type, two_stop_bits, serial_data,
    input  rx_data, data_valid, parity_error, framing_error, break_detected, busy
  );

  modport slave (
    input  enable, prescale, data_width_cfg, parity_enable, parity_type, two_stop_bits, serial_data,
    output rx_data, data_valid, parity_error, framing_error, break_detected, busy
  );
endinterface

// File: rtl/uart_rx_majority_sampler.sv
// rtl/uart_rx_majority_sampler.sv - three mid-bit samples of the rx line and their 2-of-3 vote
module uart_rx_majority_sampler #(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [PRESCALE_WIDTH-1:0] edge_cnt_i,
  input  logic [PRESCALE_WIDTH-1:0] half_i,
  input  logic                      serial_i,
  output logic                      vote_o
);
  localparam logic [PRESCALE_WIDTH-1:0] ONE = PRESCALE_WIDTH'(1);
  localparam logic [PRESCALE_WIDTH-1:0] TWO = PRESCALE_WIDTH'(2);

  logic [2:0] sample_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_q <= '0;
    end else begin
      if (edge_cnt_i == half_i - TWO) sample_q[0] <= serial_i;
      if (edge_cnt_i == half_i - ONE) sample_q[1] <= serial_i;
      if (edge_cnt_i == half_i)       sample_q[2] <= serial_i;
    end
  end

  assign vote_o = (sample_q[0] & sample_q[1]) | (sample_q[0] & sample_q[2]) | (sample_q[1] & sample_q[2]);
endmodule

// File: rtl/uart_rx_frame_controller.sv
// rtl/uart_rx_frame_controller.sv - UART receive frame FSM with parity, framing and break reporting
module uart_rx_frame_controller
  import uart_rx_pkg::*;
#(
  parameter int MAX_DATA_WIDTH = 9,
  parameter int PRESCALE_WIDTH = 6
) (
  input logic                       clk,
  input logic                       reset,
  uart_rx_frame_controller_if.slave rx_if
);
  localparam logic [PRESCALE_WIDTH-1:0] EDGE_ONE     = PRESCALE_WIDTH'(1);
  localparam logic [PRESCALE_WIDTH-1:0] PRESCALE_MIN = PRESCALE_WIDTH'(PRESCALE_8);

  rx_state_e                 state_q;
  logic [PRESCALE_WIDTH-1:0] edge_q;
  logic [PRESCALE_WIDTH-1:0] prescale_q;
  logic [3:0]                bit_q;
  logic [3:0]                width_q;
  logic [MAX_DATA_WIDTH-1:0] shift_q;
  logic [MAX_DATA_WIDTH-1:0] rx_data_q;
  logic                      par_en_q, par_type_q, two_stop_q;
  logic                      par_acc_q, par_err_q, all_zero_q;
  logic                      data_valid_q, parity_error_q, framing_error_q, break_q;

  logic [PRESCALE_WIDTH-1:0] half, vote_edge, last_edge;
  logic                      at_vote, at_last, vote, start_frame;

  assign half        = prescale_q >> 1;
  assign vote_edge   = half + EDGE_ONE;
  assign last_edge   = prescale_q - EDGE_ONE;
  assign at_vote     = (edge_q == vote_edge);
  assign at_last     = (edge_q == last_edge);
  assign start_frame = rx_if.enable && !rx_if.serial_data && (state_q == IDLE || state_q == DONE);

  uart_rx_majority_sampler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_sampler (
    .clk       (clk),
    .reset     (reset),
    .edge_cnt_i(edge_q),
    .half_i    (half),
    .serial_i  (rx_if.serial_data),
    .vote_o    (vote)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      edge_q          <= '0;
      prescale_q      <= '0;
      bit_q           <= '0;
      width_q         <= '0;
      shift_q         <= '0;
      rx_data_q       <= '0;
      par_en_q        <= 1'b0;
      par_type_q      <= 1'b0;
      two_stop_q      <= 1'b0;
      par_acc_q       <= 1'b0;
      par_err_q       <= 1'b0;
      all_zero_q      <= 1'b0;
      data_valid_q    <= 1'b0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
      break_q         <= 1'b0;
    end else begin
      data_valid_q    <= 1'b0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
      break_q         <= 1'b0;
      edge_q          <= at_last ? '0 : edge_q + EDGE_ONE;

      if (!rx_if.enable) begin
        state_q <= IDLE;
        edge_q  <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            edge_q <= '0;
            if (!rx_if.serial_data) state_q <= START;
          end
          START: begin
            if (at_vote && vote) begin
              state_q <= IDLE;
              edge_q  <= '0;
            end else if (at_last) begin
              state_q <= DATA;
            end
          end
          DATA: begin
            if (at_vote) begin
              shift_q[bit_q] <= vote;
              par_acc_q      <= par_acc_q ^ vote;
              if (vote) all_zero_q <= 1'b0;
            end
            if (at_last) begin
              if (bit_q == width_q - 4'd1) begin
                bit_q   <= '0;
                state_q <= par_en_q ? PARITY : STOP1;
              end else begin
                bit_q <= bit_q + 4'd1;
              end
            end
          end
          PARITY: begin
            if (at_vote) begin
              par_err_q <= (vote != (par_acc_q ^ par_type_q));
              if (vote) all_zero_q <= 1'b0;
            end
            if (at_last) state_q <= STOP1;
          end
          STOP1, STOP2: begin
            // A low stop bit after an all-zero frame is a line break, not a framing fault.
            if (at_vote && !vote) begin
              edge_q <= '0;
              if (all_zero_q) begin
                state_q <= BREAK_WAIT;
                break_q <= 1'b1;
              end else begin
                state_q         <= IDLE;
                framing_error_q <= 1'b1;
              end
            end else if (at_last) begin
              all_zero_q <= 1'b0;
              if (state_q == STOP1 && two_stop_q) begin
                state_q <= STOP2;
              end else begin
                state_q        <= DONE;
                rx_data_q      <= shift_q;
                data_valid_q   <= 1'b1;
                parity_error_q <= par_err_q;
              end
            end
          end
          DONE: begin
            edge_q  <= '0;
            state_q <= rx_if.serial_data ? IDLE : START;
          end
          BREAK_WAIT: begin
            if (rx_if.serial_data) begin
              state_q <= IDLE;
              edge_q  <= '0;
            end
          end
          default: begin
            state_q <= IDLE;
            edge_q  <= '0;
          end
        endcase

        // Frame setup: configuration is frozen here for the whole frame.
        if (start_frame) begin
          prescale_q <= (rx_if.prescale < PRESCALE_MIN) ? PRESCALE_MIN : rx_if.prescale;
          width_q    <= clamp_width(rx_if.data_width_cfg, MAX_DATA_WIDTH);
          par_en_q   <= rx_if.parity_enable;
          par_type_q <= rx_if.parity_type;
          two_stop_q <= rx_if.two_stop_bits;
          shift_q    <= '0;
          bit_q      <= '0;
          par_acc_q  <= 1'b0;
          par_err_q  <= 1'b0;
          all_zero_q <= 1'b1;
        end
      end
    end
  end

  assign rx_if.rx_data        = rx_data_q;
  assign rx_if.data_valid     = data_valid_q;
  assign rx_if.parity_error   = parity_error_q;
  assign rx_if.framing_error  = framing_error_q;
  assign rx_if.break_detected = break_q;
  assign rx_if.busy           = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_frame_controller.sv
// tb/tb_uart_rx_frame_controller.sv - directed frames against a frame-level outcome model
module tb_uart_rx_frame_controller;
  import uart_rx_pkg::*;

  localparam int EV_VALID = 0;
  localparam int EV_FERR  = 1;
  localparam int EV_BREAK = 2;

  typedef struct {
    int         kind;
    logic [8:0] data;
    logic       perr;
    int         when;
    int         tol;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  logic [8:0] model_rx = '0;
  ev_t        exp_q[$];

  uart_rx_frame_controller_if #(.MAX_DATA_WIDTH(9), .PRESCALE_WIDTH(6)) dut_if ();

  uart_rx_frame_controller #(
    .MAX_DATA_WIDTH(9),
    .PRESCALE_WIDTH(6)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .rx_if(dut_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, need %0h", name, act, exp);
    end
  endtask

  task automatic check_event(input int kind, input string name);
    ev_t e;
    vectors++;
    if (exp_q.size() == 0 || exp_q[0].kind != kind) begin
      miscompares++;
      $display("FAIL %s: unexpected pulse at cycle %0d", name, cyc);
    end else begin
      e = exp_q.pop_front();
      if (kind == EV_VALID) model_rx = e.data;
      if (cyc < e.when || cyc > e.when + e.tol ||
          (kind == EV_VALID && (dut_if.rx_data !== e.data || dut_if.parity_error !== e.perr))) begin
        miscompares++;
        $display("FAIL %s: got cycle %0d data %03h perr %b, need cycle %0d..%0d data %03h perr %b",
                 name, cyc, dut_if.rx_data, dut_if.parity_error, e.when, e.when + e.tol, e.data, e.perr);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      model_rx = '0;
    end else begin
      if (exp_q.size() > 0 && cyc > exp_q[0].when + exp_q[0].tol) begin
        vectors++;
        miscompares++;
        $display("FAIL missed_event: kind %0d due by cycle %0d, now %0d",
                 exp_q[0].kind, exp_q[0].when + exp_q[0].tol, cyc);
        exp_q.delete(0);
      end
      if (dut_if.data_valid)     check_event(EV_VALID, "data_valid");
      if (dut_if.framing_error)  check_event(EV_FERR, "framing_error");
      if (dut_if.break_detected) check_event(EV_BREAK, "break_detected");
      if (dut_if.parity_error && !dut_if.data_valid) begin
        vectors++;
        miscompares++;
        $display("FAIL parity_alone: got parity_error without data_valid at cycle %0d, need none", cyc);
      end
      vectors++;
      if (dut_if.rx_data !== model_rx) begin
        miscompares++;
        $display("FAIL rx_data_hold: got %03h, need %03h at cycle %0d", dut_if.rx_data, model_rx, cyc);
      end
    end
  end

  task automatic set_cfg(input int p, input int wcfg, input bit pen, input bit ptype, input bit two);
    dut_if.prescale       = 6'(p);
    dut_if.data_width_cfg = 4'(wcfg);
    dut_if.parity_enable  = pen;
    dut_if.parity_type    = ptype;
    dut_if.two_stop_bits  = two;
  endtask

  task automatic idle(input int n);
    dut_if.serial_data = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Builds the line image of one frame, predicts its outcome from the frame rules, then drives it.
  task automatic send_frame(input int p, input int wcfg, input bit pen, input bit ptype, input bit two,
                            input logic [8:0] data, input bit flip_par, input int low_stop,
                            input int abort_at, input int tol);
    bit         line[$];
    int         w;
    int         t0;
    bit         par;
    bit         all_zero;
    ev_t        e;
    logic [8:0] mask;
    w    = (wcfg < MIN_DATA_WIDTH) ? MIN_DATA_WIDTH : ((wcfg > 9) ? 9 : wcfg);
    par  = 1'b0;
    mask = '0;
    line.push_back(1'b0);
    for (int i = 0; i < w; i++) begin
      line.push_back(data[i]);
      par ^= data[i];
      mask[i] = data[i];
    end
    if (pen) line.push_back(par ^ ptype ^ flip_par);
    line.push_back(low_stop == 1 ? 1'b0 : 1'b1);
    if (two) line.push_back(low_stop == 2 ? 1'b0 : 1'b1);
    t0 = cyc;
    e.kind = EV_VALID;
    e.data = mask;
    e.perr = pen & flip_par;
    e.when = t0 + p * line.size() + 1;
    e.tol  = tol;
    for (int f = 1 + w + int'(pen); f < line.size(); f++) begin
      if (line[f] == 1'b0) begin
        all_zero = 1'b1;
        for (int k = 1; k < f; k++) if (line[k]) all_zero = 1'b0;
        e.kind = all_zero ? EV_BREAK : EV_FERR;
        e.when = t0 + p * f + p / 2 + 3;
        break;
      end
    end
    set_cfg(p, wcfg, pen, ptype, two);
    if (abort_at < 0) exp_q.push_back(e);
    for (int f = 0; f < line.size(); f++) begin
      if (f == abort_at) begin
        dut_if.enable      = 1'b0;
        dut_if.serial_data = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_busy", dut_if.busy, 0);
        dut_if.enable = 1'b1;
        return;
      end
      if (f == 2) set_cfg((p == 8) ? 16 : 8, 15 - wcfg, !pen, !ptype, !two);
      if (f == line.size() - 1) set_cfg(p, wcfg, pen, ptype, two);
      dut_if.serial_data = line[f];
      repeat (p) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    dut_if.enable      = 1'b1;
    dut_if.serial_data = 1'b1;
    set_cfg(8, 8, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rx_data", dut_if.rx_data, 0);
    chk("reset_pulses", {dut_if.data_valid, dut_if.parity_error, dut_if.framing_error, dut_if.break_detected}, 0);
    chk("reset_busy", dut_if.busy, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(4);

    send_frame(8, 8, 1'b0, 1'b0, 1'b0, 9'h0A5, 1'b0, 0, -1, 0);
    idle(8);
    chk("p8_w8_rx_data", dut_if.rx_data, 9'h0A5);

    send_frame(16, 7, 1'b1, 1'b0, 1'b0, 9'h041, 1'b1, 0, -1, 0);
    idle(16);
    chk("even_parity_rx_data", dut_if.rx_data, 9'h041);

    send_frame(32, 12, 1'b1, 1'b1, 1'b1, 9'h1FF, 1'b0, 2, -1, 0);
    idle(64);
    chk("framing_rx_kept", dut_if.rx_data, 9'h041);
    chk("framing_busy_end", dut_if.busy, 0);

    send_frame(16, 2, 1'b0, 1'b0, 1'b0, 9'h0F5, 1'b0, 0, -1, 0);
    idle(16);
    chk("min_width_rx_data", dut_if.rx_data, 9'h015);

    dut_if.prescale    = 6'(PRESCALE_16);
    dut_if.serial_data = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    dut_if.serial_data = 1'b1;
    chk("glitch_busy_start", dut_if.busy, 1);
    idle(24);
    chk("glitch_busy_end", dut_if.busy, 0);

    send_frame(8, 8, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 1, -1, 0);
    repeat (80) @(posedge clk);
    #1;
    chk("break_busy_hold", dut_if.busy, 1);
    idle(4);
    chk("break_busy_end", dut_if.busy, 0);
    chk("break_rx_kept", dut_if.rx_data, 9'h015);

    send_frame(8, 8, 1'b0, 1'b0, 1'b0, 9'h012, 1'b0, 0, -1, 0);
    send_frame(8, 8, 1'b0, 1'b0, 1'b0, 9'h034, 1'b0, 0, -1, 1);
    send_frame(8, 8, 1'b0, 1'b0, 1'b0, 9'h056, 1'b0, 0, 4, 0);
    idle(16);
    chk("b2b_busy_end", dut_if.busy, 0);
    chk("b2b_rx_data", dut_if.rx_data, 9'h034);

    dut_if.serial_data = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("midframe_reset_busy", dut_if.busy, 0);
    chk("midframe_reset_rx", dut_if.rx_data, 0);
    dut_if.serial_data = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(8);
    chk("post_reset_busy", dut_if.busy, 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
